// File: rtl/exp5_unidade_controle_if.sv
// Signal bundle between the memory-game control unit and its datapath/player-input side.
// The slave modport is the control unit's view; master is the datapath/stimulus view.
interface exp5_unidade_controle_if;
   logic       iniciar;
   logic       jogada;
   logic       igual;
   logic       fimC;
   logic       zeraC;
   logic       contaC;
   logic       zeraR;
   logic       registraR;
   logic       acertou;
   logic       errou;
   logic       timeout;
   logic       pronto;
   logic [3:0] db_estado;

   modport master (
      output iniciar, jogada, igual, fimC,
      input  zeraC, contaC, zeraR, registraR, acertou, errou, timeout, pronto, db_estado
   );

   modport slave (
      input  iniciar, jogada, igual, fimC,
      output zeraC, contaC, zeraR, registraR, acertou, errou, timeout, pronto, db_estado
   );
endinterface

// File: rtl/exp5_unidade_controle.sv
// Moore control unit sequencing one memory-game round (hit / miss / per-play timeout).
// Optional feature macro: EXP5_TIMEOUT_EN enables the ESPERA timeout timer and FIM_TIMEOUT.
module exp5_unidade_controle #(
   parameter int unsigned TIMEOUT_CYCLES = 5000
) (
   input logic                     clock,
   input logic                     reset,
   exp5_unidade_controle_if.slave  bus
);
   // state        | meaning
   // INICIAL      | idle, waiting for iniciar
   // PREPARACAO   | clear address counter and play register
   // ESPERA       | waiting for a play (timer running when enabled)
   // REGISTRA     | load play register
   // COMPARA      | evaluate comparator result
   // PROXIMO      | advance address counter
   // FIM_ACERTOU  | round over, all plays correct
   // FIM_ERROU    | round over, wrong play
   // FIM_TIMEOUT  | round over, no play in time
   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARACAO  = 4'h1,
      ESPERA      = 4'h2,
      REGISTRA    = 4'h4,
      COMPARA     = 4'h5,
      PROXIMO     = 4'h6,
      FIM_ACERTOU = 4'hA,
      FIM_TIMEOUT = 4'hD,
      FIM_ERROU   = 4'hE
   } state_t;

   state_t state;
   state_t next;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("exp5_unidade_controle: TIMEOUT_CYCLES must be at least 2");
   end

`ifdef EXP5_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] timer;

   // Counts only while staying in ESPERA, so it restarts on every entry.
   always_ff @(posedge clock) begin
      if (!reset) begin
         timer <= '0;
      end else if (state == ESPERA && next == ESPERA) begin
         timer <= timer + TW'(1);
      end else begin
         timer <= '0;
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= INICIAL;
      end else begin
         state <= next;
      end
   end

   always_comb begin
      next = state;
      case (state)
         INICIAL:     if (bus.iniciar) next = PREPARACAO;
         PREPARACAO:  next = ESPERA;
         ESPERA: begin
            if (bus.jogada) begin
               next = REGISTRA;
`ifdef EXP5_TIMEOUT_EN
            end else if (timer == TIMER_LAST) begin
               next = FIM_TIMEOUT;
`endif
            end
         end
         REGISTRA:    next = COMPARA;
         COMPARA: begin
            if (!bus.igual)     next = FIM_ERROU;
            else if (bus.fimC)  next = FIM_ACERTOU;
            else                next = PROXIMO;
         end
         PROXIMO:     next = ESPERA;
         FIM_ACERTOU: if (bus.iniciar) next = PREPARACAO;
         FIM_ERROU:   if (bus.iniciar) next = PREPARACAO;
`ifdef EXP5_TIMEOUT_EN
         FIM_TIMEOUT: if (bus.iniciar) next = PREPARACAO;
`endif
         default:     next = INICIAL;
      endcase
   end

   always_comb begin
      bus.zeraC     = 1'b0;
      bus.contaC    = 1'b0;
      bus.zeraR     = 1'b0;
      bus.registraR = 1'b0;
      bus.acertou   = 1'b0;
      bus.errou     = 1'b0;
      bus.timeout   = 1'b0;
      bus.pronto    = 1'b0;
      case (state)
         PREPARACAO: begin
            bus.zeraC = 1'b1;
            bus.zeraR = 1'b1;
         end
         REGISTRA:    bus.registraR = 1'b1;
         PROXIMO:     bus.contaC = 1'b1;
         FIM_ACERTOU: begin
            bus.pronto  = 1'b1;
            bus.acertou = 1'b1;
         end
         FIM_ERROU: begin
            bus.pronto = 1'b1;
            bus.errou  = 1'b1;
         end
`ifdef EXP5_TIMEOUT_EN
         FIM_TIMEOUT: begin
            bus.pronto  = 1'b1;
            bus.errou   = 1'b1;
            bus.timeout = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign bus.db_estado = state;
endmodule

// File: tb/tb_exp5_unidade_controle.sv
// Self-checking bench for exp5_unidade_controle: directed scenarios plus randomized rounds
// checked against a round-level outcome/pulse-count model.
module tb_exp5_unidade_controle;
   localparam int T = 8;

   logic clk = 1'b0;
   logic rst;

   exp5_unidade_controle_if bus();

   exp5_unidade_controle #(.TIMEOUT_CYCLES(T)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_zc, n_cc, n_rr;

   logic [7:0] outs;
   assign outs = {bus.zeraC, bus.contaC, bus.zeraR, bus.registraR,
                  bus.acertou, bus.errou, bus.timeout, bus.pronto};

   // Output pattern required in each state code.
   function automatic logic [7:0] exp_outs(input logic [3:0] code);
      case (code)
         4'h1:    return 8'b1010_0000;
         4'h4:    return 8'b0001_0000;
         4'h6:    return 8'b0100_0000;
         4'hA:    return 8'b0000_1001;
         4'hE:    return 8'b0000_0101;
         4'hD:    return 8'b0000_0111;
         default: return 8'b0000_0000;
      endcase
   endfunction

   // One clock: tally the pulses of the cycle being left, then sample 1 time unit after the edge.
   task automatic tick();
      n_zc += bus.zeraC     ? 1 : 0;
      n_cc += bus.contaC    ? 1 : 0;
      n_rr += bus.registraR ? 1 : 0;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_state(input string tag, input logic [3:0] code);
      chk({tag, "_state"}, {4'h0, bus.db_estado}, {4'h0, code});
      chk({tag, "_outs"}, outs, exp_outs(code));
   endtask

   // Drives a complete round open-loop; wrong_at / tmo_at select the play that ends it (-1 = none).
   task automatic run_round(input int n, input int wrong_at, input int tmo_at, input int dfix);
      int         d;
      bit         done;
      int         e_rr, e_cc;
      logic [3:0] e_code;
      n_zc = 0; n_cc = 0; n_rr = 0;
      bus.iniciar = 1'b1;
      tick();
      bus.iniciar = 1'b0;
      chk_state("prep", 4'h1);
      tick();
      chk_state("espera", 4'h2);
      done = 1'b0;
      for (int i = 0; i < n && !done; i++) begin
         bus.igual = (i != wrong_at);
         bus.fimC  = (i == n - 1);
         if (i == tmo_at) begin
            repeat (T - 1) tick();
            chk_state("tmo_last_cycle", 4'h2);
            tick();
            done = 1'b1;
         end else begin
            d = (dfix >= 0) ? dfix : int'($urandom_range(0, T - 1));
            repeat (d) tick();
            bus.jogada = 1'b1;
            tick();
            bus.jogada = 1'b0;
            chk_state("registra", 4'h4);
            tick();
            chk_state("compara", 4'h5);
            tick();
            if (i == wrong_at || i == n - 1) begin
               done = 1'b1;
            end else begin
               chk_state("proximo", 4'h6);
               tick();
               chk_state("espera_again", 4'h2);
            end
         end
      end
      if (tmo_at >= 0) begin
         e_code = 4'hD; e_rr = tmo_at;       e_cc = tmo_at;
      end else if (wrong_at >= 0) begin
         e_code = 4'hE; e_rr = wrong_at + 1; e_cc = wrong_at;
      end else begin
         e_code = 4'hA; e_rr = n;            e_cc = n - 1;
      end
      chk_state("outcome", e_code);
      chk("zeraC_pulses",     8'(n_zc), 8'd1);
      chk("registraR_pulses", 8'(n_rr), 8'(e_rr));
      chk("contaC_pulses",    8'(n_cc), 8'(e_cc));
      bus.jogada = 1'b1;
      repeat (3) tick();
      bus.jogada = 1'b0;
      chk_state("outcome_hold", e_code);
   endtask

   initial begin
      int n, mode, wrong, tmo;
      bus.iniciar = 1'b1;
      bus.jogada  = 1'b1;
      bus.igual   = 1'b0;
      bus.fimC    = 1'b0;
      rst = 1'b0;
      tick();
      tick();
      chk_state("reset", 4'h0);
      bus.iniciar = 1'b0;
      bus.jogada  = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      chk_state("post_reset", 4'h0);

      run_round(4, -1, -1, -1);
      run_round(4, 1, -1, -1);
`ifdef EXP5_TIMEOUT_EN
      run_round(3, -1, 0, -1);
      run_round(2, -1, -1, T - 1);
      run_round(3, -1, 2, T - 1);
`else
      bus.iniciar = 1'b1;
      tick();
      bus.iniciar = 1'b0;
      tick();
      repeat (100) tick();
      chk_state("no_timeout", 4'h2);
      bus.jogada = 1'b1;
      bus.igual  = 1'b1;
      bus.fimC   = 1'b1;
      tick();
      bus.jogada = 1'b0;
      chk_state("late_play", 4'h4);
      tick();
      tick();
      chk_state("late_outcome", 4'hA);
`endif

      for (int r = 0; r < 6; r++) begin
         n     = int'($urandom_range(1, 5));
         mode  = int'($urandom_range(0, 2));
         wrong = (mode == 1) ? int'($urandom_range(0, n - 1)) : -1;
         tmo   = -1;
`ifdef EXP5_TIMEOUT_EN
         if (mode == 2) tmo = int'($urandom_range(0, n - 1));
`endif
         run_round(n, wrong, tmo, -1);
      end

      bus.iniciar = 1'b1;
      tick();
      bus.iniciar = 1'b0;
      tick();
      bus.jogada = 1'b1;
      bus.igual  = 1'b1;
      bus.fimC   = 1'b1;
      tick();
      bus.jogada = 1'b0;
      tick();
      chk_state("abort_compara", 4'h5);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk_state("abort", 4'h0);
      tick();
      chk_state("abort_hold", 4'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/exp5_unidade_controle.md
# exp5_unidade_controle

Moore control unit that sequences the memory-game datapath (address counter, play register, comparator) for a sequence-match round with a per-play response timeout. It sits between the debounced/edge-detected player inputs and the datapath enables. It reports the round outcome (hit, miss, timeout) and exposes its state code for the hex debug display.

## Interface
- TIMEOUT_CYCLES, 5000, maximum number of clock cycles spent waiting for one play; must be ≥ 2. Timer width is clog2(TIMEOUT_CYCLES).
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge forces the initial state.
- iniciar  in  1  start request, level-sampled.
- jogada  in  1  single-cycle pulse: a new play is present on the switches.
- igual  in  1  comparator result: registered play equals memory word.
- fimC  in  1  address counter is at its last position.
- zeraC  out  1  synchronous clear of the address counter.
- contaC  out  1  address counter increment enable.
- zeraR  out  1  synchronous clear of the play register.
- registraR  out  1  play register load enable.
- acertou  out  1  round finished, all plays correct.
- errou  out  1  round finished by wrong play or timeout.
- timeout  out  1  round finished by timeout.
- pronto  out  1  round finished (any outcome).
- db_estado  out  4  current state code.

## Operation
- All outputs are decoded from the state register only (Moore).
- States, with codes and asserted outputs:
  - INICIAL 0x0: none. Exits to PREPARACAO when iniciar=1.
  - PREPARACAO 0x1: zeraC, zeraR; timer cleared. Exits to ESPERA.
  - ESPERA 0x2: none; timer increments each cycle.
    - jogada=1 exits to REGISTRA.
    - Otherwise, timer = TIMEOUT_CYCLES−1 exits to FIM_TIMEOUT.
  - REGISTRA 0x4: registraR. Exits to COMPARA.
  - COMPARA 0x5: none.
    - igual=0 exits to FIM_ERROU.
    - igual=1 and fimC=1 exits to FIM_ACERTOU.
    - igual=1 and fimC=0 exits to PROXIMO.
  - PROXIMO 0x6: contaC; timer cleared. Exits to ESPERA.
  - FIM_ACERTOU 0xA: pronto, acertou.
  - FIM_ERROU 0xE: pronto, errou.
  - FIM_TIMEOUT 0xD: pronto, errou, timeout.
- From any FIM_* state, iniciar=1 exits to PREPARACAO (restart without reset). Otherwise the state holds.
- Unused codes (0x3, 0x7–0x9, 0xB, 0xC, 0xF) go to INICIAL on the next edge.
- jogada is ignored in every state except ESPERA. iniciar is ignored outside INICIAL and the FIM_* states.

## Timing
- Reset: reset=0 at an edge gives state INICIAL and timer 0. All outputs are 0 and db_estado=0x0 from that edge.
  - Reset overrides every other input.
  - Reset mid-round aborts the round immediately; no outcome flag is produced.
- Outputs change only at clock edges. An output asserted by a state is high for exactly the cycles spent in that state.
  - zeraC/zeraR, registraR and contaC are each exactly one-cycle pulses.
- Latency from iniciar=1 sampled in INICIAL:
  - Edge 1: PREPARACAO.
  - Edge 2: ESPERA.
- Play path: jogada sampled in ESPERA, then REGISTRA (+1), COMPARA (+2), then the outcome state or PROXIMO (+3). With PROXIMO, ESPERA is re-entered at +4.
- Timeout: ESPERA lasts at most TIMEOUT_CYCLES cycles. FIM_TIMEOUT is entered on the edge ending cycle number TIMEOUT_CYCLES in ESPERA.
- jogada=1 in the final ESPERA cycle (timer = TIMEOUT_CYCLES−1): the play wins and the next state is REGISTRA.
- The timer restarts from 0 on every ESPERA entry. Outside ESPERA it holds at 0.

## Configuration
- Macro: EXP5_TIMEOUT_EN.
- Defined: the timeout timer and FIM_TIMEOUT behave as described above.
- Undefined:
  - The timer is not synthesized; ESPERA waits indefinitely for jogada.
  - FIM_TIMEOUT is unreachable; its code is handled as an unused code.
  - timeout is tied to 0.
  - TIMEOUT_CYCLES is accepted but unused.

## Test plan
Bench uses TIMEOUT_CYCLES=8 with EXP5_TIMEOUT_EN defined, unless noted.
- Reset: hold reset=0 for 2 cycles with iniciar=1 and jogada=1 → db_estado=0x0 and all outputs 0. Release reset with iniciar=0 → state stays 0x0.
- Full correct round of 4 plays:
  - Stimulus: iniciar pulse, then 4 jogada pulses with igual=1; fimC=1 only on the 4th.
  - Required: exactly 1 zeraC pulse, 4 registraR pulses, 3 contaC pulses.
  - Then db_estado=0xA, acertou=1, pronto=1, held until iniciar.
- Wrong play: second play with igual=0 → db_estado=0xE, errou=1, acertou=0, contaC pulsed once in total.
- Timeout: enter ESPERA and send no jogada → FIM_TIMEOUT exactly 8 edges after ESPERA entry, with timeout=errou=pronto=1.
  - Repeat with jogada in the 8th ESPERA cycle → REGISTRA, no timeout.
- Restart and abort:
  - From 0xE, assert iniciar → PREPARACAO, zeraC=zeraR=1 for one cycle.
  - Drive reset=0 while in COMPARA → 0x0 next edge with no outcome flag.
- Macro off: with EXP5_TIMEOUT_EN undefined, wait 100 cycles in ESPERA → db_estado stays 0x2 and timeout=0. Then a jogada proceeds normally.
